// File: rtl/stopwatch_if.sv
// Bundle between the stopwatch sequencer and its surroundings: raw buttons
// and live time come in, counter control and display selection go out.
// There is no valid/ready pair here: the buttons are free-running levels,
// time_in is a continuously valid level, and cnt_clr is a one-cycle pulse
// that the counter must accept unconditionally (no back-pressure exists).
interface stopwatch_if;
  logic        btn_ss;
  logic        btn_lr;
  logic [15:0] time_in;
  logic        cnt_en;
  logic        cnt_clr;
  logic [15:0] disp_bcd;
  logic        disp_blank;
  logic        running;
  logic        lap_active;
  logic [1:0]  fsm_state;

  // master: the sequencer itself
  modport master (
    input  btn_ss, btn_lr, time_in,
    output cnt_en, cnt_clr, disp_bcd, disp_blank, running, lap_active, fsm_state
  );

  // slave: pads, counter and display mux
  modport slave (
    output btn_ss, btn_lr, time_in,
    input  cnt_en, cnt_clr, disp_bcd, disp_blank, running, lap_active, fsm_state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for an MM:SS stopwatch. Debounces the
// start/stop and lap/reset buttons, gates the counter, issues clear pulses,
// selects live or frozen lap time for the display and blinks it while paused.
module stopwatch_ctrl #(
  parameter int FREQ        = 2000,
  parameter int DEBOUNCE_MS = 10,
  parameter int BLINK_HZ    = 2,
  parameter int STOP_AT_MAX = 1
) (
  input  logic        clk,
  input  logic        rst,
  stopwatch_if.master bus
);

  localparam int DB_CYCLES  = FREQ * DEBOUNCE_MS / 1000;
  localparam int BLINK_HALF = FREQ / (2 * BLINK_HZ);
  localparam int DBW        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int BLW        = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  // Button index 0 = start/stop, 1 = lap/reset
  logic [1:0]     raw;
  logic [1:0]     sync_a;
  logic [1:0]     sync_b;
  logic [1:0]     db_lvl;
  logic [1:0]     db_lvl_q;
  logic [1:0]     evt;
  logic [DBW-1:0] db_cnt [2];

  state_t         state;
  state_t         state_nx;
  logic           lap_load;
  logic           at_max;
  logic           ss_evt;
  logic           lr_evt;
  logic [15:0]    lap_reg;
  logic           cnt_en_q;
  logic           running_q;
  logic           lap_active_q;
  logic           cnt_clr_q;
  logic [BLW-1:0] blink_cnt;
  logic           blank_q;

  assign raw = {bus.btn_lr, bus.btn_ss};

  // Synchronize, debounce (level changes only after a full stable window) and
  // register a one-cycle event on each debounced rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a   <= '0;
      sync_b   <= '0;
      db_lvl   <= '0;
      db_lvl_q <= '0;
      evt      <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_a   <= raw;
      sync_b   <= sync_a;
      db_lvl_q <= db_lvl;
      evt      <= db_lvl & ~db_lvl_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Start/stop wins over a coincident lap/reset event
  assign ss_evt = evt[0];
  assign lr_evt = evt[1] & ~evt[0];
  assign at_max = (STOP_AT_MAX != 0) && (bus.time_in == 16'h5959);

  // Next-state decode; button events take priority over the max-time stop
  always_comb begin
    state_nx = state;
    lap_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (ss_evt) state_nx = S_RUN;
      end
      S_RUN: begin
        if (ss_evt) begin
          state_nx = S_PAUSE;
        end else if (lr_evt) begin
          state_nx = S_LAP;
          lap_load = 1'b1;
        end else if (at_max) begin
          state_nx = S_PAUSE;
        end
      end
      S_LAP: begin
        if (ss_evt)      state_nx = S_PAUSE;
        else if (lr_evt) state_nx = S_RUN;
        else if (at_max) state_nx = S_PAUSE;
      end
      S_PAUSE: begin
        if (ss_evt)      state_nx = S_RUN;
        else if (lr_evt) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, lap snapshot and registered decode of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      lap_reg      <= '0;
      cnt_en_q     <= 1'b0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      cnt_clr_q    <= 1'b0;
    end else begin
      state        <= state_nx;
      if (lap_load) lap_reg <= bus.time_in;
      cnt_en_q     <= (state_nx == S_RUN) || (state_nx == S_LAP);
      running_q    <= (state_nx == S_RUN) || (state_nx == S_LAP);
      lap_active_q <= (state_nx == S_LAP);
      cnt_clr_q    <= (state == S_PAUSE) && (state_nx == S_IDLE);
    end
  end

  // Pause blink: restart unblanked on entry, toggle every BLINK_HALF cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blank_q   <= 1'b0;
    end else if (state_nx == S_PAUSE) begin
      if (state != S_PAUSE) begin
        blink_cnt <= '0;
        blank_q   <= 1'b0;
      end else if (blink_cnt == BL_LAST) begin
        blink_cnt <= '0;
        blank_q   <= ~blank_q;
      end else begin
        blink_cnt <= blink_cnt + BLW'(1);
      end
    end else begin
      blink_cnt <= '0;
      blank_q   <= 1'b0;
    end
  end

  assign bus.cnt_en     = cnt_en_q;
  assign bus.running    = running_q;
  assign bus.lap_active = lap_active_q;
  assign bus.cnt_clr    = cnt_clr_q;
  assign bus.disp_blank = blank_q;
  assign bus.disp_bcd   = (state == S_LAP) ? lap_reg : bus.time_in;
  assign bus.fsm_state  = state;

endmodule
